// File: rtl/ask_fsk_pkg.sv
// Shared types and default tuning constants for the ASK/FSK key-bit demodulator.
package ask_fsk_pkg;

    typedef enum logic {
        ZC_LOW  = 1'b0,
        ZC_HIGH = 1'b1
    } zc_state_e;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MID       = 128;
    localparam int unsigned DEF_HYST      = 8;
    localparam int unsigned DEF_CW        = 10;
    localparam int unsigned DEF_PERIOD_TH = 384;
    localparam int unsigned DEF_WIN       = 512;
    localparam int unsigned DEF_ENV_TH    = 32;

endpackage

// File: rtl/zc_detect.sv
// Hysteresis crossing detector with a saturating period counter.
// Reports the rising event and the measured period combinationally.
module zc_detect
    import ask_fsk_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned MID   = DEF_MID,
    parameter int unsigned HYST  = DEF_HYST,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] sample_i,
    output logic             rise_c,
    output logic [CW:0]      period_c,
    output logic             sat_c
);

    localparam logic [WIDTH:0] HI_TH   = (WIDTH+1)'(MID + HYST);
    localparam logic [WIDTH:0] LO_TH   = (WIDTH+1)'(MID - HYST);
    localparam logic [CW-1:0]  CNT_MAX = '1;

    zc_state_e      st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0] s_ext;

    assign s_ext = {1'b0, sample_i};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= ZC_LOW;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Period includes the sample that produced the rising event.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        rise_c   = 1'b0;
        sat_c    = 1'b0;
        period_c = {1'b0, cnt_q} + (CW+1)'(1);
        if (clr_i) begin
            st_d  = ZC_LOW;
            cnt_d = '0;
        end else if (valid_i) begin
            if (st_q == ZC_LOW && s_ext >= HI_TH) begin
                st_d   = ZC_HIGH;
                rise_c = 1'b1;
            end else if (st_q == ZC_HIGH && s_ext <= LO_TH) begin
                st_d = ZC_LOW;
            end
            if (rise_c) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            sat_c = !rise_c && (cnt_d == CNT_MAX);
        end
    end

endmodule

// File: rtl/ask_fsk_demod.sv
// ASK/FSK key-bit demodulator: FSK decodes the crossing period with two-vote
// agreement, ASK decodes the windowed peak envelope against a threshold.
module ask_fsk_demod
    import ask_fsk_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MID       = DEF_MID,
    parameter int unsigned HYST      = DEF_HYST,
    parameter int unsigned CW        = DEF_CW,
    parameter int unsigned PERIOD_TH = DEF_PERIOD_TH,
    parameter int unsigned WIN       = DEF_WIN,
    parameter int unsigned ENV_TH    = DEF_ENV_TH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             mode,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             lock
);

    localparam int unsigned    WINW     = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [WINW-1:0] WIN_LAST = WINW'(WIN - 1);
    localparam logic [WIDTH:0] MID_X    = (WIDTH+1)'(MID);
    localparam logic [WIDTH:0] ENV_X    = (WIDTH+1)'(ENV_TH);
    localparam logic [CW:0]    PTH_X    = (CW+1)'(PERIOD_TH);

    logic            mode_q;
    logic            seen_q, seen_d;
    logic            hist_vld_q, hist_vld_d;
    logic            hist_q, hist_d;
    logic [WINW-1:0] win_q, win_d;
    logic [WIDTH:0]  peak_q, peak_d;
    logic            bit_out_q, bit_out_d;
    logic            bit_valid_q, bit_valid_d;
    logic            lock_q, lock_d;

    logic            mode_chg_c;
    logic            accept_c;
    logic            rise_c;
    logic            sat_c;
    logic [CW:0]     period_c;
    logic [WIDTH:0]  s_ext_c;
    logic [WIDTH:0]  mag_c;
    logic [WIDTH:0]  pk_c;
    logic            cand_c;
    logic            commit_c;

    assign mode_chg_c = (mode != mode_q);
    assign accept_c   = sample_valid && !mode_chg_c;
    assign s_ext_c    = {1'b0, sample};
    assign mag_c      = (s_ext_c >= MID_X) ? (s_ext_c - MID_X) : (MID_X - s_ext_c);
    assign pk_c       = (mag_c > peak_q) ? mag_c : peak_q;

    zc_detect #(
        .WIDTH (WIDTH),
        .MID   (MID),
        .HYST  (HYST),
        .CW    (CW)
    ) u_zc (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (mode_chg_c),
        .valid_i  (accept_c),
        .sample_i (sample),
        .rise_c   (rise_c),
        .period_c (period_c),
        .sat_c    (sat_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= 1'b0;
            seen_q      <= 1'b0;
            hist_vld_q  <= 1'b0;
            hist_q      <= 1'b0;
            win_q       <= '0;
            peak_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            mode_q      <= mode;
            seen_q      <= seen_d;
            hist_vld_q  <= hist_vld_d;
            hist_q      <= hist_d;
            win_q       <= win_d;
            peak_q      <= peak_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            lock_q      <= lock_d;
        end
    end

    // Decision logic; only the active mode's path consumes an accepted sample.
    always_comb begin
        seen_d      = seen_q;
        hist_vld_d  = hist_vld_q;
        hist_d      = hist_q;
        win_d       = win_q;
        peak_d      = peak_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        lock_d      = lock_q;
        cand_c      = 1'b0;
        commit_c    = 1'b0;
        if (mode_chg_c) begin
            seen_d     = 1'b0;
            hist_vld_d = 1'b0;
            hist_d     = 1'b0;
            win_d      = '0;
            peak_d     = '0;
            lock_d     = 1'b0;
        end else if (sample_valid) begin
            if (mode) begin
                if (rise_c) begin
                    // The first crossing only starts the period measurement.
                    if (seen_q) begin
                        cand_c     = (period_c <= PTH_X);
                        commit_c   = hist_vld_q && (hist_q == cand_c);
                        hist_vld_d = 1'b1;
                        hist_d     = cand_c;
                    end
                    seen_d = 1'b1;
                end else if (sat_c) begin
                    lock_d = 1'b0;
                end
            end else begin
                if (win_q == WIN_LAST) begin
                    cand_c   = (pk_c >= ENV_X);
                    commit_c = 1'b1;
                    win_d    = '0;
                    peak_d   = '0;
                end else begin
                    win_d  = win_q + WINW'(1);
                    peak_d = pk_c;
                end
            end
            if (commit_c) begin
                bit_out_d   = cand_c;
                bit_valid_d = 1'b1;
                lock_d      = 1'b1;
            end
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign lock      = lock_q;

endmodule

// File: tb/tb_ask_fsk_demod.sv
// Bench for ask_fsk_demod: random tones and directed edge cases compared each
// cycle against a sample-history reference model.
module tb_ask_fsk_demod;

    localparam int WIDTH     = 8;
    localparam int MID       = 128;
    localparam int HYST      = 8;
    localparam int CW        = 10;
    localparam int PERIOD_TH = 384;
    localparam int WIN       = 512;
    localparam int ENV_TH    = 32;
    localparam int CNT_SAT   = (1 << CW) - 1;
    localparam real TWO_PI   = 6.283185307179586;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] sample = '0;
    logic             mode = 1'b0;
    logic             bit_out;
    logic             bit_valid;
    logic             lock;

    ask_fsk_demod #(
        .WIDTH(WIDTH), .MID(MID), .HYST(HYST), .CW(CW),
        .PERIOD_TH(PERIOD_TH), .WIN(WIN), .ENV_TH(ENV_TH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mode         (mode),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .lock         (lock)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    real ph = 0.0;

    // Reference model state: sample indices and a history of magnitudes.
    bit m_bit, m_valid, m_lock, m_mode, m_high;
    int m_n, m_last_rise, m_rises, m_prev_cand;
    int q_mag[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_high      = 1'b0;
        m_n         = 0;
        m_last_rise = 0;
        m_rises     = 0;
        m_prev_cand = -1;
        m_lock      = 1'b0;
        q_mag.delete();
    endfunction

    function automatic void model_reset();
        model_clear();
        m_bit   = 1'b0;
        m_valid = 1'b0;
        m_mode  = 1'b0;
    endfunction

    function automatic void model_commit(input bit b);
        m_bit   = b;
        m_valid = 1'b1;
        m_lock  = 1'b1;
    endfunction

    function automatic void model_step(input bit v, input int s, input bit md);
        bit rise;
        int period, cand, mx;
        m_valid = 1'b0;
        if (md != m_mode) begin
            m_mode = md;
            model_clear();
            return;
        end
        if (!v) return;
        m_n++;
        rise = 1'b0;
        if (!m_high && s >= MID + HYST) begin
            m_high = 1'b1;
            rise   = 1'b1;
        end else if (m_high && s <= MID - HYST) begin
            m_high = 1'b0;
        end
        if (md) begin
            if (rise) begin
                period = m_n - m_last_rise;
                if (period > CNT_SAT + 1) period = CNT_SAT + 1;
                m_last_rise = m_n;
                m_rises++;
                if (m_rises >= 2) begin
                    cand = (period <= PERIOD_TH) ? 1 : 0;
                    if (m_prev_cand == cand) model_commit(cand[0]);
                    m_prev_cand = cand;
                end
            end else if (m_n - m_last_rise >= CNT_SAT) begin
                m_lock = 1'b0;
            end
        end else begin
            q_mag.push_back((s >= MID) ? s - MID : MID - s);
            if (q_mag.size() == WIN) begin
                mx = 0;
                foreach (q_mag[i]) if (q_mag[i] > mx) mx = q_mag[i];
                model_commit(mx >= ENV_TH);
                q_mag.delete();
            end
        end
    endfunction

    task automatic cyc(input bit v, input int s, input bit md);
        @(negedge clk);
        sample_valid = v;
        sample       = WIDTH'(s);
        mode         = md;
        @(posedge clk);
        model_step(v, s, md);
        #1;
        check("bit_valid", {31'd0, bit_valid}, {31'd0, m_valid});
        check("bit_out",   {31'd0, bit_out},   {31'd0, m_bit});
        check("lock",      {31'd0, lock},      {31'd0, m_lock});
        if (bit_valid) pulses++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        mode         = 1'b0;
        model_reset();
        #1;
        check("rst_bit_out",   {31'd0, bit_out},   32'd0);
        check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        check("rst_lock",      {31'd0, lock},      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ph    = 0.0;
    endtask

    // vstyle: 0 continuous, 1 alternate idle cycles, 2 random idle gaps.
    task automatic tone(input int per, input int n, input bit md, input int amp, input int vstyle);
        int s;
        for (int i = 0; i < n; i++) begin
            s = MID + int'(amp * $sin(ph)) + int'($urandom_range(2)) - 1;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            if (vstyle == 1) cyc(1'b0, int'($urandom_range(255)), md);
            else if (vstyle == 2) repeat ($urandom_range(2)) cyc(1'b0, int'($urandom_range(255)), md);
            cyc(1'b1, s, md);
            ph = ph + TWO_PI / per;
            if (ph >= TWO_PI) ph = ph - TWO_PI;
        end
    endtask

    task automatic square(input int hi, input int lo, input int half, input int nper);
        for (int p = 0; p < nper; p++) begin
            repeat (half) cyc(1'b1, hi, 1'b1);
            repeat (half) cyc(1'b1, lo, 1'b1);
        end
    endtask

    task automatic ask_spike(input int spike);
        cyc(1'b1, spike, 1'b0);
        repeat (WIN - 1) cyc(1'b1, MID, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // FSK slow tone: third rising crossing gives the first 0 decision.
        pulses = 0;
        tone(512, 2048, 1'b1, 120, 0);
        check("fsk512_pulses", pulses, 2);
        check("fsk512_bit", {31'd0, bit_out}, 32'd0);
        check("fsk512_lock", {31'd0, lock}, 32'd1);

        // Fast tone: one disagreeing vote before the first 1.
        pulses = 0;
        tone(256, 1024, 1'b1, 120, 0);
        check("fsk256_pulses", pulses, 3);
        check("fsk256_bit", {31'd0, bit_out}, 32'd1);

        // Flat input: counter saturates, lock drops, bit holds.
        repeat (1100) cyc(1'b1, MID, 1'b1);
        check("sat_lock", {31'd0, lock}, 32'd0);
        check("sat_bit", {31'd0, bit_out}, 32'd1);

        // Same slow tone with sample_valid on every other cycle.
        do_reset();
        pulses = 0;
        tone(512, 2048, 1'b1, 120, 1);
        check("gap_pulses", pulses, 2);
        check("gap_bit", {31'd0, bit_out}, 32'd0);
        check("gap_lock", {31'd0, lock}, 32'd1);

        // Mode toggle mid-period clears lock without a decision.
        tone(512, 200, 1'b1, 120, 0);
        cyc(1'b1, MID, 1'b0);
        check("toggle_lock", {31'd0, lock}, 32'd0);
        check("toggle_valid", {31'd0, bit_valid}, 32'd0);
        check("toggle_bit", {31'd0, bit_out}, 32'd0);

        // ASK: full-scale window then a flat window.
        do_reset();
        tone(512, 512, 1'b0, 127, 0);
        check("ask_on_valid", {31'd0, bit_valid}, 32'd1);
        check("ask_on_bit", {31'd0, bit_out}, 32'd1);
        repeat (512) cyc(1'b1, MID, 1'b0);
        check("ask_off_valid", {31'd0, bit_valid}, 32'd1);
        check("ask_off_bit", {31'd0, bit_out}, 32'd0);

        // Reset mid-window discards the partial envelope.
        tone(512, 300, 1'b0, 100, 0);
        do_reset();
        pulses = 0;
        tone(512, 511, 1'b0, 100, 0);
        check("rewin_early", pulses, 0);
        tone(512, 1, 1'b0, 100, 0);
        check("rewin_pulse", {31'd0, bit_valid}, 32'd1);

        // Envelope threshold is inclusive on both sides of mid.
        ask_spike(MID + ENV_TH);
        check("env_hi_edge", {31'd0, bit_out}, 32'd1);
        ask_spike(MID + ENV_TH - 1);
        check("env_below", {31'd0, bit_out}, 32'd0);
        ask_spike(MID - ENV_TH);
        check("env_lo_edge", {31'd0, bit_out}, 32'd1);

        // Crossing levels are inclusive; one code short never crosses.
        cyc(1'b1, MID, 1'b1);
        pulses = 0;
        square(MID + HYST, MID - HYST, 100, 6);
        check("hyst_edge_pulses", pulses, 4);
        check("hyst_edge_bit", {31'd0, bit_out}, 32'd1);
        pulses = 0;
        square(MID + HYST - 1, MID - HYST + 1, 100, 3);
        check("hyst_inner_pulses", pulses, 0);

        // Random tones, modes, gaps and resets.
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(3) == 0) do_reset();
            tone(150 + int'($urandom_range(550)), 300 + int'($urandom_range(1200)),
                 1'($urandom_range(1)), 10 + int'($urandom_range(117)), int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
